// File: rtl/pc_unit_if.sv
// Control-FSM to program-counter bus: update strobes and operands in, fetch/link state out.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DISP_W = 8
);
    logic              PCe;
    logic              npc_ctrl;
    logic              br_en;
    logic [DISP_W-1:0] disp;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] link_out;
    logic              pc_updated;
    logic              halted;

    modport master (
        output PCe, npc_ctrl, br_en, disp, target,
        input  pc_out, link_out, pc_updated, halted
    );

    modport slave (
        input  PCe, npc_ctrl, br_en, disp, target,
        output pc_out, link_out, pc_updated, halted
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter: edge-triggered update with increment / relative branch / absolute jump,
// link capture, and sticky halt on branch-to-self.
module pc_unit #(
    parameter int unsigned           ADDR_W   = 16,
    parameter int unsigned           DISP_W   = 8,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);
    typedef enum logic [0:0] {RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_q, link_d;
    logic              upd_q, upd_d;
    logic              halted_q, halted_d;
    logic              pce_prev_q;
    logic              trigger;
    logic [ADDR_W-1:0] disp_ext;

    // Only a fresh assertion of PCe counts; a held level must not advance twice.
    assign trigger  = bus.PCe & ~pce_prev_q;
    assign disp_ext = ADDR_W'($signed(bus.disp));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            link_q     <= RESET_PC + ADDR_W'(1);
            upd_q      <= 1'b0;
            halted_q   <= 1'b0;
            pce_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            link_q     <= link_d;
            upd_q      <= upd_d;
            halted_q   <= halted_d;
            pce_prev_q <= bus.PCe;
        end
    end

    // Next-PC selection and halt detection; jump outranks branch and masks halt.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        link_d   = link_q;
        upd_d    = 1'b0;
        halted_d = halted_q;
        case (state_q)
            RUN: begin
                if (trigger) begin
                    link_d = pc_q + ADDR_W'(1);
                    upd_d  = 1'b1;
                    if (bus.npc_ctrl) begin
                        pc_d = bus.target;
                    end else if (bus.br_en) begin
                        pc_d = pc_q + disp_ext;
                        if (bus.disp == '0) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                            upd_d    = 1'b0;
                        end
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.pc_out     = pc_q;
    assign bus.link_out   = link_q;
    assign bus.pc_updated = upd_q;
    assign bus.halted     = halted_q;
endmodule
